dcache_arbiter: RTL and testbench

Shares the single-port data cache between two requesters: req0 (execute load/store path) and req1 (debug/fill port). Uses round-robin arbitration and a valid/ready request handshake. Sequences each granted op into the cache's STR/LDR uop interface, waits out the cache's registered read latency, and returns a one-cycle response pulse to the originating requester. Sits between the execute-stage memory requesters and dcache; the arbiter is the only driver of the cache's addr/data_in/uop.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_arbiter_if.sv | 23 ++
 rtl/dcache_arbiter_rr_arbiter2.sv | 17 +
 rtl/dcache_arbiter.sv | 141 ++++++++++++++
 tb/tb_dcache_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache and its request arbiter.
package dcache_pkg;

  // Cache uop encodings
  localparam logic [4:0] STR_UOP = 5'b01001;
  localparam logic [4:0] LDR_UOP = 5'b01010;
  localparam logic [4:0] NOP_UOP = 5'b00000;

  // Number of cache words; valid addresses are 0..DC_DEPTH-1
  localparam int unsigned DC_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Latched request; id 0 = req0, id 1 = req1
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        id;
  } req_t;

endpackage

// File: rtl/dcache_arbiter_if.sv
// One requester port of the dcache arbiter: valid/ready request plus response pulse.
interface dcache_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Requester side
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dcache_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; purely combinational, the grant history lives in the caller.
// last_grant_i = 1 means req1 was granted last, so req0 wins a tie.
module rr_arbiter2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant0_o,
  output logic grant1_o
);

  // Lone requester always wins; on a tie the one not granted last wins
  always_comb begin
    grant0_o = valid0_i && (!valid1_i || last_grant_i);
    grant1_o = valid1_i && (!valid0_i || !last_grant_i);
  end

endmodule

// File: rtl/dcache_arbiter.sv
// Arbitrates two requesters onto the single-port dcache uop interface.
// Optional: define DCACHE_ARB_BOUNDS_CHECK_EN to reject addresses >= DC_DEPTH with resp_err.
module dcache_arbiter
  import dcache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  dcache_arbiter_if.slave   req0,
  dcache_arbiter_if.slave   req1,
  output logic [31:0]       dc_addr,
  output logic [31:0]       dc_data_in,
  output logic [4:0]        dc_uop,
  input  logic [31:0]       dc_data_out
);

  state_e      state_q, state_d;
  req_t        req_q, req_d, req_in;
  logic        err_q, err_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] dc_addr_q, dc_addr_d;
  logic [31:0] dc_data_in_q, dc_data_in_d;
  logic [4:0]  dc_uop_q, dc_uop_d;
  logic        grant0, grant1;
  logic        handshake;
  logic        addr_err;

  rr_arbiter2 u_rr (
    .valid0_i     (req0.req_valid),
    .valid1_i     (req1.req_valid),
    .last_grant_i (last_grant_q),
    .grant0_o     (grant0),
    .grant1_o     (grant1)
  );

  // Select the granted requester's payload and flag out-of-range addresses
  always_comb begin
    req_in.write = grant1 ? req1.req_write : req0.req_write;
    req_in.addr  = grant1 ? req1.req_addr  : req0.req_addr;
    req_in.wdata = grant1 ? req1.req_wdata : req0.req_wdata;
    req_in.id    = grant1;
    handshake    = (state_q == IDLE) && (grant0 || grant1);
`ifdef DCACHE_ARB_BOUNDS_CHECK_EN
    addr_err     = (req_in.addr >= 32'(DC_DEPTH));
`else
    addr_err     = 1'b0;
`endif
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; error ops spend the issue slot idle so they share the store latency
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (handshake) state_d = ISSUE;
      ISSUE:   state_d = (req_q.write || err_q) ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: cache uop for the coming cycle, handshake readies and response ports
  always_comb begin
    dc_uop_d     = NOP_UOP;
    dc_addr_d    = dc_addr_q;
    dc_data_in_d = dc_data_in_q;
    if ((state_d == ISSUE) && !err_d) begin
      dc_uop_d     = req_d.write ? STR_UOP : LDR_UOP;
      dc_addr_d    = req_d.addr;
      dc_data_in_d = req_d.write ? req_d.wdata : 32'd0;
    end
  end

  assign req0.req_ready  = (state_q == IDLE) && grant0;
  assign req1.req_ready  = (state_q == IDLE) && grant1;
  assign req0.resp_valid = (state_q == RESP) && !req_q.id;
  assign req1.resp_valid = (state_q == RESP) &&  req_q.id;
  assign req0.resp_err   = (state_q == RESP) && !req_q.id && err_q;
  assign req1.resp_err   = (state_q == RESP) &&  req_q.id && err_q;
  assign req0.resp_rdata = rdata0_q;
  assign req1.resp_rdata = rdata1_q;
  assign dc_addr         = dc_addr_q;
  assign dc_data_in      = dc_data_in_q;
  assign dc_uop          = dc_uop_q;

  // Request latch, grant history and per-port response data
  always_comb begin
    req_d        = req_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    if (handshake) begin
      req_d        = req_in;
      err_d        = addr_err;
      last_grant_d = req_in.id;
    end
    // Response data is loaded only on entry to RESP so each port holds its last result
    if ((state_d == RESP) && (state_q != RESP)) begin
      if (req_q.id) begin
        rdata1_d = (state_q == WAIT) ? dc_data_out : 32'd0;
      end else begin
        rdata0_d = (state_q == WAIT) ? dc_data_out : 32'd0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q        <= '0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      dc_addr_q    <= '0;
      dc_data_in_q <= '0;
      dc_uop_q     <= NOP_UOP;
    end else begin
      req_q        <= req_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      dc_addr_q    <= dc_addr_d;
      dc_data_in_q <= dc_data_in_d;
      dc_uop_q     <= dc_uop_d;
    end
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// Self-checking bench for dcache_arbiter with a small behavioural cache model.
module tb_dcache_arbiter;
  import dcache_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] dc_addr, dc_data_in, dc_data_out;
  logic [4:0]  dc_uop;
  int          errors = 0;
  int          checks = 0;

  dcache_arbiter_if if0 ();
  dcache_arbiter_if if1 ();

  dcache_arbiter dut (
    .clock       (clk),
    .reset       (rst),
    .req0        (if0),
    .req1        (if1),
    .dc_addr     (dc_addr),
    .dc_data_in  (dc_data_in),
    .dc_uop      (dc_uop),
    .dc_data_out (dc_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: store on STR, register mem on LDR, zero otherwise
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (dc_uop == STR_UOP) mem[dc_addr[4:0]] <= dc_data_in;
    if (dc_uop == LDR_UOP) dc_data_out <= mem[dc_addr[4:0]];
    else                   dc_data_out <= 32'd0;
  end

  typedef struct {
    int          port;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? if1.req_ready : if0.req_ready;
  endfunction

  function automatic logic rv(input int p);
    return (p == 1) ? if1.resp_valid : if0.resp_valid;
  endfunction

  function automatic logic [31:0] rd(input int p);
    return (p == 1) ? if1.resp_rdata : if0.resp_rdata;
  endfunction

  function automatic logic re(input int p);
    return (p == 1) ? if1.resp_err : if0.resp_err;
  endfunction

  task automatic drive(input int p, input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    if (p == 1) begin
      if1.req_valid = v; if1.req_write = w; if1.req_addr = a; if1.req_wdata = d;
    end else begin
      if0.req_valid = v; if0.req_write = w; if0.req_addr = a; if0.req_wdata = d;
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in the following IDLE cycle
  task automatic do_op(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err, input bit exp_now,
                       input string nm);
    int n;
    int rk;
    logic [4:0] exp_uop;
    drive(p, 1'b1, w, a, d);
    #1;
    if (exp_now) chk({nm, "_ready_now"}, 32'(rdy(p)), 32'd1);
    n = 0;
    while (!rdy(p) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (!rdy(p)) begin
      chk({nm, "_ready_timeout"}, 32'(rdy(p)), 32'd1);
      drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      return;
    end
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    rk = (w || exp_err) ? 2 : 3;
    exp_uop = exp_err ? NOP_UOP : (w ? STR_UOP : LDR_UOP);
    for (int k = 1; k <= rk; k++) begin
      #1;
      if (k == 1) begin
        chk({nm, "_uop_issue"}, 32'(dc_uop), 32'(exp_uop));
        if (!exp_err) begin
          chk({nm, "_dc_addr"}, dc_addr, a);
          chk({nm, "_dc_data_in"}, dc_data_in, w ? d : 32'd0);
        end
      end else begin
        chk({nm, "_uop_nop"}, 32'(dc_uop), 32'(NOP_UOP));
      end
      if (k < rk) begin
        chk({nm, "_resp_early"}, 32'(rv(p)), 32'd0);
      end else begin
        chk({nm, "_resp_valid"}, 32'(rv(p)), 32'd1);
        chk({nm, "_resp_rdata"}, rd(p), exp_rd);
        chk({nm, "_resp_err"}, 32'(re(p)), 32'(exp_err));
        chk({nm, "_resp_other"}, 32'(rv(1 - p)), 32'd0);
      end
      @(negedge clk);
    end
    #1;
    chk({nm, "_resp_drop"}, 32'(rv(p)), 32'd0);
    chk({nm, "_rdata_hold"}, rd(p), exp_rd);
  endtask

  initial begin
    int gq [$];
    int order [$];
    int nresp;
    bit stop;
    logic r0, r1;
    int gid;

    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    dc_data_out = 32'd0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    vecs[0]  = '{0, 1'b1, 32'd5,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'd5,  32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1, 1'b1, 32'd9,  32'h22222222, 32'h0};
    vecs[3]  = '{1, 1'b0, 32'd9,  32'h0,        32'h22222222};
    vecs[4]  = '{0, 1'b1, 32'd0,  32'hA5A50000, 32'h0};
    vecs[5]  = '{1, 1'b0, 32'd0,  32'h0,        32'hA5A50000};
    vecs[6]  = '{0, 1'b1, 32'd7,  32'h11111111, 32'h0};
    vecs[7]  = '{1, 1'b0, 32'd5,  32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1, 1'b1, 32'd31, 32'h31313131, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'd31, 32'h0,        32'h31313131};
    vecs[10] = '{1, 1'b0, 32'd7,  32'h0,        32'h11111111};

    // Reset and idle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("idle_uop", 32'(dc_uop), 32'(NOP_UOP));
      chk("idle_resp", {30'd0, if1.resp_valid, if0.resp_valid}, 32'd0);
      chk("idle_ready0", 32'(if0.req_ready), 32'd0);
    end
    chk("rst_dc_addr", dc_addr, 32'd0);
    chk("rst_dc_data_in", dc_data_in, 32'd0);
    chk("rst_rdata", if0.resp_rdata | if1.resp_rdata, 32'd0);
    chk("rst_err", {30'd0, if1.resp_err, if0.resp_err}, 32'd0);
    @(negedge clk);

    // Directed single-requester table
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].port, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
            1'b0, 1'b1, $sformatf("vec%0d", i));
    end

    // Both requesters hold loads: grants alternate, responses route to the right port
    drive(0, 1'b1, 1'b0, 32'd7, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd9, 32'd0);
    nresp = 0;
    stop = 1'b0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      #1;
      r0 = if0.req_ready;
      r1 = if1.req_ready;
      if (r0 && r1) chk("rr_one_ready", 32'(r0 && r1), 32'd0);
      if ((r0 || r1) && !stop) begin
        gq.push_back(r1 ? 1 : 0);
        order.push_back(r1 ? 1 : 0);
        if (order.size() == 4) stop = 1'b1;
      end
      if (if0.resp_valid || if1.resp_valid) begin
        gid = (gq.size() > 0) ? gq.pop_front() : -1;
        chk("rr_resp_single", 32'(if0.resp_valid && if1.resp_valid), 32'd0);
        chk("rr_resp_port", 32'(if1.resp_valid), 32'(gid));
        chk("rr_resp_rdata", if1.resp_valid ? if1.resp_rdata : if0.resp_rdata,
            (gid == 1) ? 32'h22222222 : 32'h11111111);
        nresp++;
      end
      @(negedge clk);
      if (stop) begin
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    chk("rr_resp_count", 32'(nresp), 32'd4);
    chk("rr_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
    end
    #1;
    chk("rr_final_idle", 32'(dc_uop), 32'(NOP_UOP));

    // req0 held during a req1 load: no ready until IDLE, then req0 wins the tie
    drive(1, 1'b1, 1'b0, 32'd9, 32'd0);
    #1;
    chk("hold_r1_ready", 32'(if1.req_ready), 32'd1);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("hold_r0_blocked%0d", k), 32'(if0.req_ready), 32'd0);
      if (k == 3) begin
        chk("hold_r1_resp", 32'(if1.resp_valid), 32'd1);
        chk("hold_r1_rdata", if1.resp_rdata, 32'h22222222);
      end
      @(negedge clk);
    end
    #1;
    chk("hold_r0_granted", 32'(if0.req_ready), 32'd1);
    chk("hold_r1_lost", 32'(if1.req_ready), 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("hold_r0_uop", 32'(dc_uop), 32'(LDR_UOP));
    @(negedge clk); @(negedge clk); #1;
    chk("hold_r0_resp", 32'(if0.resp_valid), 32'd1);
    chk("hold_r0_rdata", if0.resp_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Reset during the WAIT cycle of a req1 load drops it silently
    drive(1, 1'b1, 1'b0, 32'd3, 32'd0);
    #1;
    chk("rst_mid_ready", 32'(if1.req_ready), 32'd1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("rst_mid_issue", 32'(dc_uop), 32'(LDR_UOP));
    @(negedge clk); #1;
    chk("rst_mid_wait", 32'(dc_uop), 32'(NOP_UOP));
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_uop", 32'(dc_uop), 32'(NOP_UOP));
    chk("rst_mid_noresp", 32'(if1.resp_valid), 32'd0);
    rst = 1'b0;
    do_op(0, 1'b1, 32'd12, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, "after_rst");
    chk("rst_mid_noresp_late", 32'(if1.resp_valid), 32'd0);
    do_op(0, 1'b0, 32'd12, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, "after_rst_ld");

    // Out-of-range address
`ifdef DCACHE_ARB_BOUNDS_CHECK_EN
    do_op(0, 1'b0, 32'd32, 32'h0, 32'h0, 1'b1, 1'b1, "oob_ld");
    do_op(1, 1'b1, 32'd40, 32'h12345678, 32'h0, 1'b1, 1'b1, "oob_st");
`else
    do_op(0, 1'b0, 32'd32, 32'h0, 32'hA5A50000, 1'b0, 1'b1, "oob_ld");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
